// File: rtl/ark_round_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ark_round_stage: AddRoundKey state register and round sequencer for an iterative AES-style
// cipher; the S-box/shift/mix datapath sits outside and returns its result on fb_data.
module ark_round_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  input  logic [127:0] fb_data,
  output logic [127:0] RKO,
  output logic         mode_o,
  output logic         last_rnd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [3:0] NR_C = 4'(NR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       eff_mode;

  // Before a block is latched the key index must follow the live mode input.
  assign eff_mode  = (state == IDLE) ? mode : mode_o;
  assign rk_idx    = eff_mode ? (NR_C - cnt) : cnt;
  assign last_rnd  = (state == ROUND) && (cnt == NR_C);
  assign out_valid = (state == DONE);
  assign out_data  = out_valid ? RKO : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      RKO      <= '0;
      mode_o   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            RKO      <= in_data ^ rk;
            mode_o   <= mode;
            cnt      <= 4'd1;
            state    <= ROUND;
            in_ready <= 1'b0;
          end else begin
            // Ready rises one cycle after entering IDLE, both after reset and after DONE.
            in_ready <= 1'b1;
          end
        end
        ROUND: begin
          RKO <= fb_data ^ rk;
          if (cnt == NR_C) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= 4'd0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
